// File: rtl/led_pkg.sv
// Shared state and mode encodings for the LED sequencer.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHASE  = 2'd1,
        FLICK  = 2'd2,
        BYPASS = 2'd3
    } led_state_t;

    typedef enum logic [1:0] {
        LED_MODE_NORMAL = 2'd0,
        LED_MODE_BLINK  = 2'd1,
        LED_MODE_CHASE  = 2'd2
    } led_mode_t;

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter with duty compare; all-ones duty means fully on.
module led_pwm #(
    parameter int unsigned PWM_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic [PWM_W-1:0] duty_i,
    output logic             pwm_on_c
);

    logic [PWM_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PWM_W'(1);
        end
    end

    assign pwm_on_c = (duty_i == '1) || (cnt_q < duty_i);

endmodule

// File: rtl/led_sequencer.sv
// Power-up chase/flick sequencer that hands the LED pins to PWM-dimmed status LEDs.
module led_sequencer
    import led_pkg::*;
#(
    parameter int unsigned N_LEDS    = 4,
    parameter int unsigned STEP_W    = 22,
    parameter int unsigned FLICK_CNT = 2,
    parameter int unsigned PWM_W     = 8,
    parameter int unsigned USE_TICK  = 0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              sample_tick_i,
    input  logic [1:0]        mode_i,
    input  logic              restart_i,
    input  logic [N_LEDS-1:0] leds_i,
    input  logic [PWM_W-1:0]  brightness_i,
    output logic [N_LEDS-1:0] leds_o,
    output logic              busy_o
);

    localparam int unsigned IDX_W = $clog2(N_LEDS);
    localparam int unsigned PH_W  = $clog2(2 * FLICK_CNT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_LEDS - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * FLICK_CNT - 1);

    led_state_t        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [N_LEDS-1:0] pattern;
    logic              step_en;
    logic              strobe;
    logic              pwm_on;

    assign step_en = (USE_TICK != 0) ? sample_tick_i : 1'b1;
    assign strobe  = step_en && (step_q == '1);

    led_pwm #(
        .PWM_W (PWM_W)
    ) u_pwm (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clr_i    (restart_i),
        .duty_i   (brightness_i),
        .pwm_on_c (pwm_on)
    );

    // Next-state: sequence decisions only happen on the strobe at the end of a step.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        if (restart_i) begin
            state_d = IDLE;
            step_d  = '0;
            idx_d   = '0;
            phase_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    step_d  = '0;
                    idx_d   = '0;
                    phase_d = '0;
                    state_d = (mode_i == LED_MODE_BLINK) ? FLICK : CHASE;
                end
                CHASE: begin
                    if (step_en) step_d = step_q + STEP_W'(1);
                    if (strobe) begin
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            if (mode_i != LED_MODE_CHASE) state_d = FLICK;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                FLICK: begin
                    if (step_en) step_d = step_q + STEP_W'(1);
                    if (strobe) begin
                        if (phase_q == PH_LAST) begin
                            phase_d = '0;
                            if (mode_i == LED_MODE_CHASE) begin
                                state_d = CHASE;
                            end else if (mode_i != LED_MODE_BLINK) begin
                                state_d = BYPASS;
                            end
                        end else begin
                            phase_d = phase_q + PH_W'(1);
                        end
                    end
                end
                BYPASS: begin
                    // Held at zero so a mode-driven re-entry starts with a full step.
                    step_d = '0;
                    if (mode_i == LED_MODE_BLINK) begin
                        state_d = FLICK;
                        phase_d = '0;
                    end else if (mode_i == LED_MODE_CHASE) begin
                        state_d = CHASE;
                        idx_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // LED pattern for the current state; registered below so pins never glitch.
    always_comb begin
        pattern = '0;
        case (state_q)
            CHASE:   pattern = N_LEDS'(1) << idx_q;
            FLICK:   pattern = phase_q[0] ? '1 : '0;
            BYPASS:  pattern = leds_i & {N_LEDS{pwm_on}};
            default: pattern = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            step_q  <= '0;
            idx_q   <= '0;
            phase_q <= '0;
            leds_o  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            leds_o  <= pattern;
        end
    end

    assign busy_o = (state_q != BYPASS);

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: free-running and tick-gated instances against a sequence-position model.
module tb_led_sequencer;

    localparam int N    = 4;
    localparam int FC   = 2;
    localparam int STEP = 8;
    localparam int NPOS = N + 2 * FC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] leds_in = 4'b1010;
    logic [7:0] bright = 8'hFF;
    logic [3:0] leds0, leds1;
    logic       busy0, busy1;

    always #5 clk = ~clk;

    led_sequencer #(.N_LEDS(4), .STEP_W(3), .FLICK_CNT(2), .PWM_W(8), .USE_TICK(0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .sample_tick_i(tick), .mode_i(mode), .restart_i(restart),
        .leds_i(leds_in), .brightness_i(bright), .leds_o(leds0), .busy_o(busy0)
    );

    led_sequencer #(.N_LEDS(4), .STEP_W(3), .FLICK_CNT(2), .PWM_W(8), .USE_TICK(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .sample_tick_i(tick), .mode_i(mode), .restart_i(restart),
        .leds_i(leds_in), .brightness_i(bright), .leds_o(leds1), .busy_o(busy1)
    );

    // pos 0..N-1 are chase steps, N..NPOS-1 are flick steps; age counts enables within a step.
    typedef struct {
        bit         idle;
        bit         byp;
        int         pos;
        int         age;
        int         pwm;
        logic [3:0] q;
    } model_t;

    typedef struct {
        logic [3:0] l;
        logic [7:0] b;
        int         on_cnt;
    } vec_t;

    model_t     m0, m1;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] rec[110];
    logic [3:0] expv[8];
    vec_t       tbl[6];

    function automatic logic [3:0] pat(model_t m);
        if (m.idle) return 4'h0;
        if (m.byp) return (bright == 8'hFF || m.pwm < int'(bright)) ? leds_in : 4'h0;
        if (m.pos < N) return 4'(1 << m.pos);
        return ((m.pos - N) % 2 == 1) ? 4'hF : 4'h0;
    endfunction

    function automatic model_t adv(model_t m, bit use_tick);
        model_t n = m;
        n.q = pat(m);
        if (restart) begin
            n.idle = 1'b1; n.byp = 1'b0; n.pos = 0; n.age = 0; n.pwm = 0;
            return n;
        end
        n.pwm = (m.pwm + 1) % 256;
        if (m.idle) begin
            n.idle = 1'b0;
            n.pos  = (mode == 2'd1) ? N : 0;
            n.age  = 0;
        end else if (m.byp) begin
            if (mode == 2'd1) begin
                n.byp = 1'b0; n.pos = N; n.age = 0;
            end else if (mode == 2'd2) begin
                n.byp = 1'b0; n.pos = 0; n.age = 0;
            end
        end else if (!use_tick || tick) begin
            if (m.age < STEP - 1) begin
                n.age = m.age + 1;
            end else begin
                n.age = 0;
                if (m.pos == N - 1) n.pos = (mode == 2'd2) ? 0 : N;
                else if (m.pos == NPOS - 1) begin
                    if (mode == 2'd1) n.pos = N;
                    else if (mode == 2'd2) n.pos = 0;
                    else n.byp = 1'b1;
                end else n.pos = m.pos + 1;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m0 = '{idle: 1'b1, byp: 1'b0, pos: 0, age: 0, pwm: 0, q: 4'h0};
        m1 = m0;
    endtask

    task automatic step();
        @(posedge clk);
        m0 = adv(m0, 1'b0);
        m1 = adv(m1, 1'b1);
        #1;
        chk("leds0", 32'(leds0), 32'(m0.q));
        chk("busy0", 32'(busy0), 32'(!m0.byp));
        chk("leds1", 32'(leds1), 32'(m1.q));
        chk("busy1", 32'(busy1), 32'(!m1.byp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, bad, on;
        logic [3:0] f;

        expv = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'hF, 4'h0, 4'hF};
        tbl[0] = '{l: 4'b1010, b: 8'd64,  on_cnt: 64};
        tbl[1] = '{l: 4'b1010, b: 8'd0,   on_cnt: 0};
        tbl[2] = '{l: 4'b1010, b: 8'd255, on_cnt: 256};
        tbl[3] = '{l: 4'b0101, b: 8'd128, on_cnt: 128};
        tbl[4] = '{l: 4'b1111, b: 8'd1,   on_cnt: 1};
        tbl[5] = '{l: 4'b0110, b: 8'd254, on_cnt: 254};

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_leds0", 32'(leds0), 32'h0);
        chk("rst_busy0", 32'(busy0), 32'h1);
        chk("rst_leds1", 32'(leds1), 32'h0);
        chk("rst_busy1", 32'(busy1), 32'h1);
        rst_n = 1'b1;

        // Normal power-up sequence; tick-gated instance sees a tick every 4th clock
        cnt = 0;
        for (int c = 0; c < 110; c++) begin
            tick = (c % 4 == 3);
            step();
            rec[c] = leds0;
            if (leds1 == 4'b0010) cnt++;
        end
        chk("seq_idle", 32'(rec[0]), 32'h0);
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++)
                chk("seq_step", 32'(rec[1 + 8 * k + j]), 32'(expv[k]));
        chk("seq_bypass", 32'(rec[65]), 32'(leds_in));
        chk("tick_step_len", 32'(cnt), 32'd32);

        // Tick held low freezes the tick-gated instance
        tick = 1'b0;
        f = leds1;
        repeat (40) step();
        chk("tick_freeze", 32'(leds1), 32'(f));

        // Restart both into the sequence, run to bypass, then sweep PWM duties
        tick = 1'b1;
        restart = 1'b1;
        step();
        restart = 1'b0;
        repeat (70) step();
        for (int i = 0; i < 6; i++) begin
            leds_in = tbl[i].l;
            bright  = tbl[i].b;
            on = 0;
            bad = 0;
            for (int c = 0; c < 256; c++) begin
                step();
                if (leds0 == tbl[i].l) on++;
                else if (leds0 != 4'h0) bad++;
            end
            chk("pwm_on_cycles", 32'(on), 32'(tbl[i].on_cnt));
            chk("pwm_shape", 32'(bad), 32'd0);
        end

        // Restart mid-flick: IDLE next cycle, chase restarts with a full first step
        leds_in = 4'b1010;
        bright  = 8'hFF;
        restart = 1'b1;
        step();
        restart = 1'b0;
        repeat (40) step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_busy", 32'(busy0), 32'h1);
        for (int j = 0; j < 10; j++) begin
            step();
            rec[j] = leds0;
        end
        chk("restart_idle", 32'(rec[0]), 32'h0);
        for (int j = 1; j < 9; j++) chk("restart_chase0", 32'(rec[j]), 32'h1);
        chk("restart_chase1", 32'(rec[9]), 32'h2);

        // Constant chase requested from bypass never reaches flick
        repeat (80) step();
        mode = 2'd2;
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (leds0 == 4'hF) cnt++;
        end
        chk("chase_no_flick", 32'(cnt), 32'd0);

        // Constant blink: half the cycles all-on, busy never drops
        mode = 2'd1;
        repeat (100) step();
        cnt = 0;
        bad = 0;
        for (int c = 0; c < 64; c++) begin
            step();
            if (leds0 == 4'hF) cnt++;
            if (!busy0) bad++;
        end
        chk("blink_on", 32'(cnt), 32'd32);
        chk("blink_busy", 32'(bad), 32'd0);

        // Asynchronous reset between edges mid-chase
        mode = 2'd0;
        restart = 1'b1;
        step();
        restart = 1'b0;
        repeat (12) step();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_leds0", 32'(leds0), 32'h0);
        chk("arst_busy0", 32'(busy0), 32'h1);
        chk("arst_leds1", 32'(leds1), 32'h0);
        chk("arst_busy1", 32'(busy1), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            restart = ($urandom_range(0, 299) == 0);
            tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                leds_in = 4'($urandom);
                bright  = 8'($urandom);
            end
            step();
        end
        restart = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
